// File: rtl/seq_pipe_add4_pkg.sv
// Shared types for the two-requester pipelined 4-input adder.
package seq_pipe_add4_pkg;

    localparam int NREQ  = 2;
    localparam int NBITS = 8;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic [NBITS-1:0] in3;
        logic [NBITS-1:0] in2;
        logic [NBITS-1:0] in1;
        logic [NBITS-1:0] in0;
    } add4_msg_t;

endpackage

// File: rtl/seq_pipe_add4_2stage_stall.sv
// Two-stage 4-operand adder datapath; both stages advance only when en is high,
// carrying a valid bit and requester ID alongside the data.
module seq_pipe_add4_2stage_stall
    import seq_pipe_add4_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               in_val_i,
    input  req_id_t            in_id_i,
    input  logic [4*nbits-1:0] in_msg_i,
    output logic               out_val_o,
    output req_id_t            out_id_o,
    output logic [nbits-1:0]   out_sum_o
);

    logic [nbits-1:0] in0_s;
    logic [nbits-1:0] in1_s;
    logic [nbits-1:0] in2_s;
    logic [nbits-1:0] in3_s;

    logic             s1_val_q,   s1_val_d;
    req_id_t          s1_id_q,    s1_id_d;
    logic [nbits-1:0] s1_sum01_q, s1_sum01_d;
    logic [nbits-1:0] s1_sum23_q, s1_sum23_d;
    logic             s2_val_q,   s2_val_d;
    req_id_t          s2_id_q,    s2_id_d;
    logic [nbits-1:0] s2_sum_q,   s2_sum_d;

    assign in0_s = in_msg_i[0*nbits +: nbits];
    assign in1_s = in_msg_i[1*nbits +: nbits];
    assign in2_s = in_msg_i[2*nbits +: nbits];
    assign in3_s = in_msg_i[3*nbits +: nbits];

    // Next-state: load both stages when enabled, otherwise hold everything
    always_comb begin
        s1_val_d   = s1_val_q;
        s1_id_d    = s1_id_q;
        s1_sum01_d = s1_sum01_q;
        s1_sum23_d = s1_sum23_q;
        s2_val_d   = s2_val_q;
        s2_id_d    = s2_id_q;
        s2_sum_d   = s2_sum_q;
        if (en_i) begin
            s1_val_d   = in_val_i;
            s1_id_d    = in_id_i;
            s1_sum01_d = in0_s + in1_s;
            s1_sum23_d = in2_s + in3_s;
            s2_val_d   = s1_val_q;
            s2_id_d    = s1_id_q;
            s2_sum_d   = s1_sum01_q + s1_sum23_q;
        end else begin
            s1_val_d   = s1_val_q;
            s2_val_d   = s2_val_q;
        end
    end

    // Pipeline registers; reset clears in-flight operations and data
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_val_q   <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_sum01_q <= {nbits{1'b0}};
            s1_sum23_q <= {nbits{1'b0}};
            s2_val_q   <= 1'b0;
            s2_id_q    <= 1'b0;
            s2_sum_q   <= {nbits{1'b0}};
        end else begin
            s1_val_q   <= s1_val_d;
            s1_id_q    <= s1_id_d;
            s1_sum01_q <= s1_sum01_d;
            s1_sum23_q <= s1_sum23_d;
            s2_val_q   <= s2_val_d;
            s2_id_q    <= s2_id_d;
            s2_sum_q   <= s2_sum_d;
        end
    end

    assign out_val_o = s2_val_q;
    assign out_id_o  = s2_id_q;
    assign out_sum_o = s2_sum_q;

endmodule

// File: rtl/seq_pipe_add4_arb2.sv
// Two requesters share one stalled 2-stage 4-input adder through a round-robin
// arbiter; the requester ID rides the pipeline to steer each result home.
module seq_pipe_add4_arb2
    import seq_pipe_add4_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [4*nbits-1:0] req0_msg,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [4*nbits-1:0] req1_msg,
    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [nbits-1:0]   resp0_msg,
    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [nbits-1:0]   resp1_msg
);

    logic [NREQ-1:0]    req_val_s;
    logic [NREQ-1:0]    req_rdy_s;
    logic [NREQ-1:0]    resp_rdy_s;
    logic               gnt_val_s;
    req_id_t            gnt_id_s;
    logic               fire_s;
    logic               stall_s;
    logic [4*nbits-1:0] gnt_msg_s;
    logic               prio_q, prio_d;
    logic               s2_val_s;
    req_id_t            s2_id_s;
    logic [nbits-1:0]   s2_sum_s;

    assign req_val_s  = {req1_val, req0_val};
    assign resp_rdy_s = {resp1_rdy, resp0_rdy};

    // A waiting result blocks the whole pipe, whichever requester owns it
    assign stall_s = s2_val_s && !resp_rdy_s[s2_id_s];

    // Grant: favoured requester on contention, else whichever is asking
    always_comb begin
        gnt_val_s = 1'b0;
        gnt_id_s  = 1'b0;
        case (req_val_s)
            2'b11: begin
                gnt_val_s = 1'b1;
                gnt_id_s  = prio_q;
            end
            2'b01: begin
                gnt_val_s = 1'b1;
                gnt_id_s  = 1'b0;
            end
            2'b10: begin
                gnt_val_s = 1'b1;
                gnt_id_s  = 1'b1;
            end
            default: begin
                gnt_val_s = 1'b0;
                gnt_id_s  = 1'b0;
            end
        endcase
    end

    // Ready only to the granted requester, and never while stalled or in reset
    always_comb begin
        req_rdy_s = {NREQ{1'b0}};
        if (!reset && !stall_s && gnt_val_s) begin
            req_rdy_s[gnt_id_s] = 1'b1;
        end else begin
            req_rdy_s = {NREQ{1'b0}};
        end
    end

    assign fire_s    = |(req_val_s & req_rdy_s);
    assign gnt_msg_s = gnt_id_s[0] ? req1_msg : req0_msg;

    // Round robin: after a fire the other requester becomes favoured
    always_comb begin
        prio_d = prio_q;
        if (fire_s) begin
            prio_d = ~gnt_id_s[0];
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    seq_pipe_add4_2stage_stall #(
        .nbits (nbits)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .en_i      (!stall_s),
        .in_val_i  (fire_s),
        .in_id_i   (gnt_id_s),
        .in_msg_i  (gnt_msg_s),
        .out_val_o (s2_val_s),
        .out_id_o  (s2_id_s),
        .out_sum_o (s2_sum_s)
    );

    assign req0_rdy  = req_rdy_s[0];
    assign req1_rdy  = req_rdy_s[1];
    assign resp0_val = s2_val_s && (s2_id_s == 1'b0);
    assign resp1_val = s2_val_s && (s2_id_s == 1'b1);
    // Sum is broadcast to both ports; only the matching val qualifies it
    assign resp0_msg = s2_sum_s;
    assign resp1_msg = s2_sum_s;

endmodule

// File: tb/tb_seq_pipe_add4_arb2.sv
// Scoreboard bench for seq_pipe_add4_arb2: fired requests push a model sum,
// handshaken responses pop and compare; scenario tasks add targeted checks.
module tb_seq_pipe_add4_arb2;
    import seq_pipe_add4_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_val = 1'b0, req1_val = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [31:0] req0_msg = 32'h0, req1_msg = 32'h0;
    logic        resp0_val, resp1_val;
    logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic [7:0]  resp0_msg, resp1_msg;

    int total = 0;
    int bad = 0;
    int n0 = 0;
    int n1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    seq_pipe_add4_arb2 #(.nbits(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_val  (req0_val),
        .req0_rdy  (req0_rdy),
        .req0_msg  (req0_msg),
        .req1_val  (req1_val),
        .req1_rdy  (req1_rdy),
        .req1_msg  (req1_msg),
        .resp0_val (resp0_val),
        .resp0_rdy (resp0_rdy),
        .resp0_msg (resp0_msg),
        .resp1_val (resp1_val),
        .resp1_rdy (resp1_rdy),
        .resp1_msg (resp1_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3);
        add4_msg_t m;
        m.in0 = a0;
        m.in1 = a1;
        m.in2 = a2;
        m.in3 = a3;
        return m;
    endfunction

    function automatic logic [7:0] model(input logic [31:0] raw);
        add4_msg_t m;
        logic [7:0] acc;
        m = raw;
        acc = m.in0;
        acc = acc + m.in1;
        acc = acc + m.in2;
        acc = acc + m.in3;
        return acc;
    endfunction

    // Called at the negedge: scoreboard bookkeeping, then advance to posedge+1.
    task automatic tick();
        logic [7:0] e;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (resp0_val && resp0_rdy) begin
                total++;
                n0++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_resp0 unexpected got=%0h want=none", resp0_msg);
                end else begin
                    e = q0.pop_front();
                    if (resp0_msg !== e) begin
                        bad++;
                        $display("FAIL sb_resp0 got=%0h want=%0h", resp0_msg, e);
                    end
                end
            end
            if (resp1_val && resp1_rdy) begin
                total++;
                n1++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_resp1 unexpected got=%0h want=none", resp1_msg);
                end else begin
                    e = q1.pop_front();
                    if (resp1_msg !== e) begin
                        bad++;
                        $display("FAIL sb_resp1 got=%0h want=%0h", resp1_msg, e);
                    end
                end
            end
            if (req0_val && req0_rdy) q0.push_back(model(req0_msg));
            if (req1_val && req1_rdy) q1.push_back(model(req1_msg));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_val = 1'b0;
        req1_val = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        for (int i = 0; i < 12 && (q0.size() != 0 || q1.size() != 0); i++) begin
            @(negedge clk);
            tick();
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending q0=%0d q1=%0d want=0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        total++;
        if ({resp0_val, resp1_val, req0_rdy, req1_rdy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {resp0_val, resp1_val, req0_rdy, req1_rdy});
        end
        total++;
        if (resp0_msg !== 8'h00 || resp1_msg !== 8'h00) begin
            bad++;
            $display("FAIL reset_msg got=%0h/%0h want=0/0", resp0_msg, resp1_msg);
        end
        tick();
        reset = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0_val = 1'b1;
        req0_msg = mk(8'd1, 8'd2, 8'd3, 8'd4);
        @(negedge clk);
        total++;
        if (req0_rdy !== 1'b1) begin
            bad++;
            $display("FAIL single_rdy got=%b want=1", req0_rdy);
        end
        tick();
        req0_val = 1'b0;
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", resp0_val);
        end
        tick();
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1 || resp0_msg !== 8'd10 || resp1_val !== 1'b0) begin
            bad++;
            $display("FAIL single_resp got=%b/%0d/%b want=1/10/0", resp0_val, resp0_msg, resp1_val);
        end
        tick();
        drain("single");
    endtask

    task automatic test_back_to_back();
        int b0, b1;
        do_reset();
        b0 = n0;
        b1 = n1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        req0_msg = mk(8'd1, 8'd1, 8'd1, 8'd1);
        req1_msg = mk(8'd2, 8'd2, 8'd2, 8'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (req0_rdy !== (i % 2 == 0) || req1_rdy !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL b2b_grant cyc=%0d got=%b%b want=%b%b", i, req1_rdy, req0_rdy,
                         (i % 2 == 1), (i % 2 == 0));
            end
            if (i >= 2) begin
                total++;
                if (i % 2 == 0) begin
                    if (resp0_val !== 1'b1 || resp1_val !== 1'b0 || resp0_msg !== 8'd4) begin
                        bad++;
                        $display("FAIL b2b_resp0 cyc=%0d got=%b%b/%0d want=01/4", i, resp1_val, resp0_val, resp0_msg);
                    end
                end else begin
                    if (resp1_val !== 1'b1 || resp0_val !== 1'b0 || resp1_msg !== 8'd8) begin
                        bad++;
                        $display("FAIL b2b_resp1 cyc=%0d got=%b%b/%0d want=10/8", i, resp1_val, resp0_val, resp1_msg);
                    end
                end
            end
            tick();
        end
        drain("b2b");
        total++;
        if (n0 - b0 != 4 || n1 - b1 != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d/%0d want=4/4", n0 - b0, n1 - b1);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ov_msg[4];
        logic [7:0]  ov_exp[4];
        int k;
        ov_msg[0] = mk(8'd127, 8'd1, 8'd0, 8'd0);
        ov_msg[1] = mk(8'h80, 8'h80, 8'h80, 8'h80);
        ov_msg[2] = mk(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        ov_msg[3] = mk(8'hFF, 8'h00, 8'h00, 8'h80);
        ov_exp[0] = 8'h80;
        ov_exp[1] = 8'h00;
        ov_exp[2] = 8'h00;
        ov_exp[3] = 8'h7F;
        k = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req1_val = (i < 4);
            req1_msg = ov_msg[i % 4];
            @(negedge clk);
            if (resp1_val && k < 4) begin
                total++;
                if (resp1_msg !== ov_exp[k]) begin
                    bad++;
                    $display("FAIL overflow_%0d got=%0h want=%0h", k, resp1_msg, ov_exp[k]);
                end
                k++;
            end
            tick();
        end
        total++;
        if (k != 4) begin
            bad++;
            $display("FAIL overflow_count got=%0d want=4", k);
        end
        drain("overflow");
    endtask

    task automatic test_backpressure();
        int b0;
        do_reset();
        b0 = n0;
        resp0_rdy = 1'b0;
        req0_val = 1'b1;
        req0_msg = mk(8'd1, 8'd2, 8'd3, 8'd4);
        @(negedge clk);
        tick();
        req0_msg = mk(8'd5, 8'd5, 8'd5, 8'd5);
        @(negedge clk);
        tick();
        req0_msg = mk(8'd7, 8'd0, 8'd0, 8'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++;
            if (resp0_val !== 1'b1 || resp0_msg !== 8'd10 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got=%b/%0d rdy=%b%b want=1/10 rdy=00", j, resp0_val,
                         resp0_msg, req1_rdy, req0_rdy);
            end
            tick();
        end
        resp0_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1 || resp0_msg !== 8'd10 || req0_rdy !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b/%0d rdy=%b want=1/10 rdy=1", resp0_val, resp0_msg, req0_rdy);
        end
        tick();
        req0_val = 1'b0;
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1 || resp0_msg !== 8'd20) begin
            bad++;
            $display("FAIL bp_second got=%b/%0d want=1/20", resp0_val, resp0_msg);
        end
        tick();
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1 || resp0_msg !== 8'd7) begin
            bad++;
            $display("FAIL bp_third got=%b/%0d want=1/7", resp0_val, resp0_msg);
        end
        tick();
        drain("bp");
        total++;
        if (n0 - b0 != 3) begin
            bad++;
            $display("FAIL bp_count got=%0d want=3", n0 - b0);
        end
    endtask

    task automatic test_hol();
        do_reset();
        resp1_rdy = 1'b0;
        req1_val = 1'b1;
        req1_msg = mk(8'd2, 8'd2, 8'd2, 8'd2);
        @(negedge clk);
        total++;
        if (req1_rdy !== 1'b1) begin
            bad++;
            $display("FAIL hol_fire got=%b want=1", req1_rdy);
        end
        tick();
        req1_val = 1'b0;
        @(negedge clk);
        tick();
        req0_val = 1'b1;
        req0_msg = mk(8'd3, 8'd3, 8'd3, 8'd3);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++;
            if (req0_rdy !== 1'b0 || resp1_val !== 1'b1 || resp1_msg !== 8'd8) begin
                bad++;
                $display("FAIL hol_block cyc=%0d got=rdy%b/%b/%0d want=rdy0/1/8", j, req0_rdy,
                         resp1_val, resp1_msg);
            end
            tick();
        end
        resp1_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (req0_rdy !== 1'b1) begin
            bad++;
            $display("FAIL hol_unblock got=%b want=1", req0_rdy);
        end
        tick();
        req0_val = 1'b0;
        drain("hol");
    endtask

    task automatic test_reset_mid();
        do_reset();
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        req0_val = 1'b1;
        req1_val = 1'b1;
        req0_msg = mk(8'd1, 8'd1, 8'd1, 8'd1);
        req1_msg = mk(8'd2, 8'd2, 8'd2, 8'd2);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b1) begin
            bad++;
            $display("FAIL rmid_inflight got=%b want=1", resp0_val);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        req0_msg = mk(8'd4, 8'd4, 8'd4, 8'd4);
        req1_msg = mk(8'd5, 8'd5, 8'd5, 8'd5);
        @(negedge clk);
        total++;
        if (resp0_val !== 1'b0 || resp1_val !== 1'b0) begin
            bad++;
            $display("FAIL rmid_flush got=%b%b want=00", resp1_val, resp0_val);
        end
        total++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_prio got=%b%b want=01", req1_rdy, req0_rdy);
        end
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;
        drain("rmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_hol();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pipe_add4_arb2.md
Name: seq_pipe_add4_arb2

Overview:
- Shares one 2-stage pipelined 4-input adder between two requesters.
- Each requester presents four operands on a val/rdy request interface and receives the sum on its own val/rdy response interface.
- A round-robin arbiter admits at most one request per cycle.
- A requester ID travels with each operation through the pipeline so the result is steered back to the correct requester. Backpressure stalls the whole pipeline.

Parameters:
- nbits, 8, width of each operand and of every sum

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_val  input  1  requester 0 request valid
- req0_rdy  output  1  requester 0 request accepted this cycle when high with req0_val
- req0_msg  input  4*nbits  {in3,in2,in1,in0}; in0 in LSBs
- req1_val  input  1  requester 1 request valid
- req1_rdy  output  1  requester 1 request ready
- req1_msg  input  4*nbits  same packing as req0_msg
- resp0_val  output  1  result for requester 0 valid
- resp0_rdy  input  1  requester 0 can take result
- resp0_msg  output  nbits  sum for requester 0
- resp1_val  output  1  result for requester 1 valid
- resp1_rdy  input  1  requester 1 can take result
- resp1_msg  output  nbits  sum for requester 1

Behaviour:
- State:
  - s1_val, s1_id, s1_sum01, s1_sum23 (stage 1)
  - s2_val, s2_id, s2_sum (stage 2)
  - prio (1 bit, the favoured requester)
- Reset (synchronous, wins over all other activity, including mid-operation): all valid bits 0, all data/ID registers 0, prio 0. In-flight operations are discarded.
- Reset output values:
  - resp0_val = resp1_val = 0
  - resp0_msg = resp1_msg = 0
  - req0_rdy = req1_rdy = 0 while reset is high
- Stall: stall = s2_val && !respX_rdy, where X = s2_id.
- Grant (combinational):
  - Both valid: grant prio.
  - Only one valid: grant that one.
  - Neither valid: no grant.
- reqX_rdy = !reset && !stall && grant==X. rdy may depend on val within the same cycle.
- Fire: reqX_val && reqX_rdy. At most one fire per cycle.
- Round robin: on a fire by X, prio <= ~X. With no fire, prio holds.
- When !stall, each edge:
  - s1_val <= fire
  - s1_id <= granted ID
  - s1_sum01 <= in0+in1
  - s1_sum23 <= in2+in3
  - s2_val <= s1_val; s2_id <= s1_id; s2_sum <= s1_sum01+s1_sum23
- When stall: s1 and s2 hold (including when s1 is empty). No request is accepted.
- respX_val = s2_val && (s2_id==X).
- resp0_msg = resp1_msg = s2_sum. Not gated, so respY_msg may show another requester's data while respY_val is low.
- Latency: request firing in cycle N gives resp val high in cycle N+2 when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when responses are always ready.
- Arithmetic:
  - All adds are modulo 2^nbits; carries are dropped.
  - Operands are treated as unsigned bit patterns, so two's-complement wraps naturally.
  - Example (nbits=8): 127+1 = 0x80; 0x80*4 = 0x00.
- Simultaneous events:
  - A response draining (respX_rdy high) in the same cycle as a new fire is legal; the pipeline advances.
  - A stall on requester 1's result also blocks requester 0. This head-of-line blocking is intended.
- Ordering: responses to each requester return in request order.

Decomposition:
- Package seq_pipe_add4_pkg: localparam NREQ=2; typedef of the packed 4-operand message struct {in3,in2,in1,in0}; requester ID typedef (1 bit).
- One natural sub-module, seq_pipe_add4_2stage_stall: the 2-stage adder datapath with en (= !stall), carrying val and id.
- The arbiter and stall logic stay in the top.

Test Plan:
- Single requester, response always ready: req0 {1,2,3,4} fires at cycle 0 → resp0_val=1, msg=10 at cycle 2; resp1_val stays 0.
- Both requesters valid every cycle, all resp_rdy=1:
  - req0 {1,1,1,1}, req1 {2,2,2,2}
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - Responses alternate resp0 msg=4, resp1 msg=8 at one per cycle.
- Overflow: req1 {127,1,0,0} → 0x80; {0x80,0x80,0x80,0x80} → 0x00; {-64,-64,-64,-64} → 0x00; {-1,0,0,-128} → 0x7F.
- Backpressure:
  - resp0_rdy=0 with result 10 in s2 → resp0_val held high and msg held at 10 for 3 cycles; both req rdy=0; s1 result held.
  - Raising resp0_rdy drains in order with no loss or duplication.
- Head-of-line blocking: s2 holds a req1 result while resp1_rdy=0 and req0_val=1 → req0_rdy=0 until resp1_rdy rises.
- Reset mid-operation: two operations in flight, assert reset one cycle → resp0/1_val=0 the next cycle, no stale responses after deassert, prio=0 (req0 wins the first contended grant).
